// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module   : wb_arb_pkg
// Brief    : Shared types, default widths and helpers for the Wishbone arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TERM = 2'd2
    } arb_state_t;

    localparam int c_DEF_AW = 32;
    localparam int c_DEF_DW = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first requester after the last
//            grant index, with wrap. One-hot grant plus valid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          i_req,
    input  logic [clog2(N)-1:0]   i_last_grant,
    output logic [N-1:0]          o_grant,
    output logic                  o_valid
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    // Requesters strictly above the last grant win before wrapping to bit 0.
    for (genvar j = 0; j < N; j++) begin : g_mask
        assign w_mask[j] = (j > int'(i_last_grant));
    end

    assign w_hi    = i_req & w_mask;
    assign w_sel   = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_sel & (~w_sel + N'(1));
    assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Round-robin arbiter sharing one Wishbone classic slave among
//            NUM_MASTERS masters. Optional stall timeout: WB_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int AW             = c_DEF_AW,
    parameter int DW             = c_DEF_DW,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int c_SW = DW / 8;
    localparam int c_IW = clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_rr_arbiter: parameter out of range");
    end

    arb_state_t             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [c_IW-1:0]        r_last, w_last_nxt;
    logic [NUM_MASTERS-1:0] w_pick_grant;
    logic                   w_pick_valid;
    logic [c_IW-1:0]        w_gidx;
    logic                   w_busy;
    logic                   w_tmo_hit;
    logic                   w_g_cyc, w_g_stb, w_g_we;
    logic [AW-1:0]          w_g_adr;
    logic [DW-1:0]          w_g_dat;
    logic [c_SW-1:0]        w_g_sel;

    rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
        .i_req        (m_cyc_i),
        .i_last_grant (r_last),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    // One-hot AND-OR mux of the granted master's request signals.
    always_comb begin
        w_gidx  = '0;
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        w_g_sel = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_gidx  = c_IW'(k);
                w_g_cyc = m_cyc_i[k];
                w_g_stb = m_stb_i[k];
                w_g_we  = m_we_i[k];
                w_g_adr = m_adr_i[k*AW +: AW];
                w_g_dat = m_dat_i[k*DW +: DW];
                w_g_sel = m_sel_i[k*c_SW +: c_SW];
            end
        end
    end

    assign w_busy  = (r_state == BUSY);
    assign s_cyc_o = w_busy & w_g_cyc;
    assign s_stb_o = w_busy & w_g_stb;
    assign s_we_o  = w_busy & w_g_we;
    assign s_adr_o = w_busy ? w_g_adr : '0;
    assign s_dat_o = w_busy ? w_g_dat : '0;
    assign s_sel_o = w_busy ? w_g_sel : '0;
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;
    assign m_ack_o = (w_busy && s_ack_i && !w_tmo_hit) ? r_grant : '0;
    assign m_err_o = ((w_busy && s_err_i) || w_tmo_hit) ? r_grant : '0;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_TW = clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_busy && s_stb_o && !s_ack_i && !s_err_i && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = w_busy && (r_tmo_cnt == c_TW'(TIMEOUT_CYCLES));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= c_IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_grant;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_g_cyc) begin
                    w_last_nxt  = w_gidx;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = TERM;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            TERM: begin
                if (!w_g_cyc) begin
                    w_last_nxt  = w_gidx;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, hand-written corner sequences and
// randomized traffic against an owner/last-grant reference model.
`default_nettype none

module tb_wb_rr_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [127:0]  m_adr_i, m_dat_i;
    logic [15:0]   m_sel_i;
    logic [31:0]   m_dat_o;
    logic [3:0]    m_ack_o, m_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [3:0]    grant_o;

    wb_rr_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cyc;
        logic       ack;
        logic       err;
        logic [3:0] e_grant;
        logic       e_scyc;
        logic [3:0] e_ack;
        logic [3:0] e_err;
    } vec_t;

    vec_t        tbl[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          owner, last, cand;
    logic [3:0]  e_grant, e_ack, e_err;
    logic [2:0]  e_ctl;
    logic [67:0] e_bus;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] cyc, input logic ack, input logic err,
                           input logic [3:0] eg, input logic es, input logic [3:0] ea,
                           input logic [3:0] ee);
        vec_t v;
        v.cyc = cyc; v.ack = ack; v.err = err;
        v.e_grant = eg; v.e_scyc = es; v.e_ack = ea; v.e_err = ee;
        tbl.push_back(v);
    endtask

    // Fixed address pattern used by the directed phases.
    function automatic logic [31:0] adr_of(input logic [3:0] g);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) if (g[k]) r = 32'hA000_0000 + 32'(k);
        return r;
    endfunction

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        m_cyc_i = 4'hF; m_stb_i = 4'hF; m_we_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            m_adr_i[k*32 +: 32] = 32'hA000_0000 + 32'(k);
            m_dat_i[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            m_sel_i[k*4 +: 4]   = 4'(k + 1);
        end
        s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 32'hC000_0000;
        repeat (3) @(posedge clk);
        #5;
        check("rst_grant", grant_o, 4'h0);
        check("rst_slave_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("rst_slave_bus", {s_adr_o, s_dat_o, s_sel_o}, 68'h0);
        check("rst_ack_err", {m_ack_o, m_err_o}, 8'h00);
        check("rst_dat_bcast", m_dat_o, 32'hC000_0000);
        tick();
        rst = 1'b0; m_we_i = 4'h0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // ---------------- vector table ----------------
        foreach (tbl[i]) tbl.delete(i);
        for (int n = 0; n < 5; n++) begin
            logic [3:0] g;
            g = 4'(1 << (n % 4));
            add_vec(4'hF,      1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
            add_vec(4'hF,      1'b1, 1'b0, g,    1'b1, g,    4'h0);
            add_vec(4'hF & ~g, 1'b0, 1'b0, g,    1'b0, 4'h0, 4'h0);
        end
        add_vec(4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
        add_vec(4'h2, 1'b0, 1'b1, 4'h2, 1'b1, 4'h0, 4'h2);
        add_vec(4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 4'h0, 4'h0);
        add_vec(4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            m_cyc_i = tbl[i].cyc; m_stb_i = tbl[i].cyc;
            s_ack_i = tbl[i].ack; s_err_i = tbl[i].err;
            #4;
            check($sformatf("tbl%0d_grant", i), grant_o, tbl[i].e_grant);
            check($sformatf("tbl%0d_ackerr", i), {m_ack_o, m_err_o}, {tbl[i].e_ack, tbl[i].e_err});
            check($sformatf("tbl%0d_slave", i), {s_cyc_o, s_stb_o, s_adr_o},
                  {tbl[i].e_scyc, tbl[i].e_scyc, adr_of(tbl[i].e_grant)});
            tick();
        end
        s_ack_i = 1'b0; s_err_i = 1'b0;

        // ---------------- master 2 burst holds off master 1 ----------------
        m_cyc_i = 4'b0110; m_stb_i = 4'b0110;
        #4; check("hold_idle_grant", grant_o, 4'h0);
        tick();
        for (int k = 0; k < 6; k++) begin
            m_stb_i = (k % 2 == 0) ? 4'b0110 : 4'b0010;
            s_ack_i = (k % 2 == 0);
            #4;
            check($sformatf("hold%0d_grant", k), grant_o, 4'b0100);
            check($sformatf("hold%0d_ack", k), m_ack_o, (k % 2 == 0) ? 4'b0100 : 4'b0000);
            check($sformatf("hold%0d_adr", k), s_adr_o, adr_of(4'b0100));
            tick();
        end
        m_cyc_i = 4'b0010; m_stb_i = 4'b0010; s_ack_i = 1'b0;
        #4; check("hold_release_scyc", s_cyc_o, 1'b0);
        tick();
        #4; check("hold_dead_cycle", grant_o, 4'h0);
        tick();
        #4;
        check("hold_m1_grant", grant_o, 4'b0010);
        check("hold_m1_adr", s_adr_o, adr_of(4'b0010));
        tick();
        m_cyc_i = 4'h0; m_stb_i = 4'h0;
        tick();

        // ---------------- reset mid-BUSY on master 3 ----------------
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        tick();
        s_ack_i = 1'b1;
        #2;
        check("rstmid_pre_ack", {s_cyc_o, grant_o, m_ack_o}, {1'b1, 4'b1000, 4'b1000});
        #1 rst = 1'b1;
        #1;
        check("rstmid_drop", {s_cyc_o, grant_o, m_ack_o}, {1'b0, 4'b0000, 4'b0000});
        tick();
        rst = 1'b0; s_ack_i = 1'b0;
        m_cyc_i = 4'b1001; m_stb_i = 4'b1001; s_dat_i = 32'hC000_0000;
        #4; check("rd_t0_scyc", {s_cyc_o, grant_o}, {1'b0, 4'h0});
        tick();
        #4; check("rd_t1_scyc", {s_cyc_o, grant_o, m_ack_o}, {1'b1, 4'b0001, 4'b0000});
        tick();
        s_ack_i = 1'b1;
        #4;
        check("rd_t2_ack", m_ack_o, 4'b0001);
        check("rd_t2_dat", m_dat_o, 32'hC000_0000);
        tick();
        m_cyc_i = 4'h0; m_stb_i = 4'h0; s_ack_i = 1'b0;
        tick();
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- stall timeout ----------------
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        tick();
        for (int k = 0; k <= 16; k++) begin
            #4;
            check($sformatf("tmo%0d_scyc", k), s_cyc_o, 1'b1);
            check($sformatf("tmo%0d_err", k), m_err_o, (k == 16) ? 4'b0001 : 4'b0000);
            tick();
        end
        for (int k = 17; k < 20; k++) begin
            s_ack_i = (k == 18);
            #4;
            check($sformatf("term%0d_slave", k), {s_cyc_o, s_stb_o}, 2'b00);
            check($sformatf("term%0d_ackerr", k), {m_ack_o, m_err_o}, 8'h00);
            tick();
        end
        s_ack_i = 1'b0; m_cyc_i = 4'h0; m_stb_i = 4'h0;
        #4; check("term_release_scyc", s_cyc_o, 1'b0);
        tick();
        #4; check("term_idle_grant", grant_o, 4'h0);
        tick();
`endif

        // ---------------- randomized traffic vs. model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        owner = -1; last = 3;
        m_cyc_i = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(3) == 0) m_cyc_i[k] = ~m_cyc_i[k];
            m_stb_i = 4'($urandom());
            m_we_i  = 4'($urandom());
            m_adr_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_sel_i = 16'($urandom());
            s_ack_i = ($urandom_range(2) == 0) || (n % 8 == 0);
            s_err_i = ($urandom_range(7) == 0);
            s_dat_i = $urandom();
            #4;
            if (owner >= 0) begin
                e_grant = 4'(1 << owner);
                e_ctl   = {m_cyc_i[owner], m_stb_i[owner], m_we_i[owner]};
                e_bus   = {m_adr_i[owner*32 +: 32], m_dat_i[owner*32 +: 32], m_sel_i[owner*4 +: 4]};
                e_ack   = s_ack_i ? e_grant : 4'h0;
                e_err   = s_err_i ? e_grant : 4'h0;
            end else begin
                e_grant = 4'h0; e_ctl = 3'b000; e_bus = '0; e_ack = 4'h0; e_err = 4'h0;
            end
            check($sformatf("rand%0d_ctl", n), {grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, m_dat_o},
                  {e_grant, e_ctl, e_ack, e_err, s_dat_i});
            check($sformatf("rand%0d_bus", n), {s_adr_o, s_dat_o, s_sel_o}, e_bus);
            if (owner < 0) begin
                for (int d = 1; d <= 4; d++) begin
                    cand = (last + d) % 4;
                    if (owner < 0 && m_cyc_i[cand]) owner = cand;
                end
            end else if (!m_cyc_i[owner]) begin
                last  = owner;
                owner = -1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
